// File: rtl/usb_pkg.sv
// Shared USB receive definitions: PIDs, packet kinds, CRC constants and length constants.
package usb_pkg;

    typedef enum logic [1:0] {
        KindToken     = 2'd0,
        KindData      = 2'd1,
        KindHandshake = 2'd2,
        KindBad       = 2'd3
    } pkt_kind_e;

    localparam logic [3:0] PidReserved = 4'b0000;
    localparam logic [3:0] PidOut      = 4'b0001;
    localparam logic [3:0] PidIn       = 4'b1001;
    localparam logic [3:0] PidSetup    = 4'b1101;
    localparam logic [3:0] PidData0    = 4'b0011;
    localparam logic [3:0] PidData1    = 4'b1011;
    localparam logic [3:0] PidAck      = 4'b0010;
    localparam logic [3:0] PidNak      = 4'b1010;

    localparam logic [4:0]  Crc5Poly     = 5'h05;
    localparam logic [4:0]  Crc5Init     = 5'h1F;
    localparam logic [4:0]  Crc5Residue  = 5'h0C;
    localparam logic [15:0] Crc16Poly    = 16'h8005;
    localparam logic [15:0] Crc16Init    = 16'hFFFF;
    localparam logic [15:0] Crc16Residue = 16'h800D;

    localparam int unsigned PidBits       = 8;
    localparam int unsigned TokenFieldBits = 11;
    localparam int unsigned TokenBits     = 24;
    localparam int unsigned HandshakeBits = 8;
    // PID byte plus CRC16 around a data payload.
    localparam int unsigned DataOvhdBits  = 24;

    function automatic logic pid_is_data(input logic [3:0] pid);
        return (pid == PidData0) || (pid == PidData1);
    endfunction

endpackage

// File: rtl/usb_crc_lfsr.sv
// Serial CRC register; ok_o reflects the residue including any bit shifted in this cycle.
module usb_crc_lfsr #(
    parameter int unsigned     WIDTH   = 5,
    parameter logic [WIDTH-1:0] POLY    = '0,
    parameter logic [WIDTH-1:0] INIT    = '1,
    parameter logic [WIDTH-1:0] RESIDUE = '0
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clr_i,
    input  logic en_i,
    input  logic bit_i,
    output logic ok_o
);

    logic [WIDTH-1:0] r_q, r_d;

    // Next register value with the incoming bit folded in.
    always_comb begin
        r_d = r_q;
        if (en_i) begin
            r_d = {r_q[WIDTH-2:0], 1'b0} ^ ((r_q[WIDTH-1] ^ bit_i) ? POLY : '0);
        end
    end

    assign ok_o = (r_d == RESIDUE);

    // Clear wins over shift so a packet ending on a bit leaves a fresh register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)     r_q <= INIT;
        else if (clr_i) r_q <= INIT;
        else            r_q <= r_d;
    end

endmodule

// File: rtl/usb_pkt_rx.sv
// Bit-serial USB packet receiver: assembles PID/body, checks CRC and length, buffers one record.
module usb_pkt_rx import usb_pkg::*; #(
    parameter int unsigned  MAX_DATA_BYTES = 8,
    localparam int unsigned CNT_W  = $clog2(8 * MAX_DATA_BYTES + 25),
    localparam int unsigned LEN_W  = $clog2(MAX_DATA_BYTES + 1),
    localparam int unsigned DATA_W = 8 * MAX_DATA_BYTES
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              bit_in_avail,
    input  logic              bit_in,
    input  logic              eop,
    output logic              pkt_valid,
    input  logic              pkt_ready,
    output logic [3:0]        pkt_pid,
    output pkt_kind_e         pkt_kind,
    output logic [6:0]        pkt_addr,
    output logic [3:0]        pkt_endp,
    output logic [DATA_W-1:0] pkt_data,
    output logic [LEN_W-1:0]  pkt_len,
    output logic              pkt_pid_err,
    output logic              pkt_crc_err,
    output logic              pkt_len_err,
    output logic [7:0]        drop_cnt
);

    typedef enum logic [1:0] {StIdle, StRxPid, StRxBody} rx_state_e;

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        pid_q, pid_d;
    logic [10:0]       tok_q, tok_d;
    logic [15:0]       dly_q, dly_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              crc_en, crc5_ok, crc16_ok, complete, load, drop;
    logic              dec_pid_err, dec_crc_err, dec_len_err;
    pkt_kind_e         dec_kind;
    logic [LEN_W-1:0]  dec_len;
    int unsigned       cnt_u, nbytes;

    assign crc_en   = bit_in_avail && (cnt_q >= CNT_W'(PidBits));
    assign complete = eop && ((state_q != StIdle) || bit_in_avail);
    assign load     = complete && (!pkt_valid || pkt_ready);
    assign drop     = complete && pkt_valid && !pkt_ready;

    usb_crc_lfsr #(.WIDTH(5), .POLY(Crc5Poly), .INIT(Crc5Init), .RESIDUE(Crc5Residue)) u_crc5 (
        .clk(clk), .rst_b(rst_b), .clr_i(complete), .en_i(crc_en), .bit_i(bit_in), .ok_o(crc5_ok)
    );

    usb_crc_lfsr #(.WIDTH(16), .POLY(Crc16Poly), .INIT(Crc16Init), .RESIDUE(Crc16Residue))
    u_crc16 (
        .clk(clk), .rst_b(rst_b), .clr_i(complete), .en_i(crc_en), .bit_i(bit_in), .ok_o(crc16_ok)
    );

    // Fold the current bit into the assembly registers; payload lags by 16 bits to skip the CRC.
    always_comb begin
        cnt_d  = cnt_q;
        pid_d  = pid_q;
        tok_d  = tok_q;
        dly_d  = dly_q;
        data_d = data_q;
        if (bit_in_avail) begin
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
            if (cnt_q < CNT_W'(PidBits)) begin
                pid_d = {bit_in, pid_q[7:1]};
            end else begin
                if (cnt_q < CNT_W'(PidBits + TokenFieldBits)) tok_d = {bit_in, tok_q[10:1]};
                dly_d = {bit_in, dly_q[15:1]};
                for (int unsigned i = 0; i < DATA_W; i++) begin
                    if (32'(cnt_q) == DataOvhdBits + i) data_d[i] = dly_q[0];
                end
            end
        end
    end

    // Decode the record as it stands after this cycle's bit.
    always_comb begin
        cnt_u       = 32'(cnt_d);
        dec_pid_err = (pid_d[7:4] != ~pid_d[3:0]) || (pid_d[3:0] == PidReserved) ||
                      (cnt_u < PidBits);
        dec_kind    = KindBad;
        dec_crc_err = 1'b0;
        dec_len_err = 1'b0;
        unique case (pid_d[1:0])
            2'b01: begin
                dec_kind    = KindToken;
                dec_crc_err = !crc5_ok;
                dec_len_err = (cnt_u != TokenBits);
            end
            2'b11: begin
                dec_kind    = pid_is_data(pid_d[3:0]) ? KindData : KindBad;
                dec_crc_err = !crc16_ok;
                dec_len_err = (cnt_u < DataOvhdBits) || (cnt_u[2:0] != 3'd0) ||
                              (cnt_u > DataOvhdBits + 8 * MAX_DATA_BYTES);
            end
            2'b10: begin
                dec_kind    = KindHandshake;
                dec_len_err = (cnt_u != HandshakeBits);
            end
            2'b00: dec_kind = KindBad;
        endcase
        if (cnt_u < PidBits) dec_len_err = 1'b1;
        if (dec_pid_err)     dec_kind    = KindBad;
        nbytes = (cnt_u >= DataOvhdBits) ? (cnt_u - DataOvhdBits) >> 3 : 0;
        if (nbytes > MAX_DATA_BYTES) nbytes = MAX_DATA_BYTES;
        dec_len = (dec_kind == KindData) ? LEN_W'(nbytes) : '0;
    end

    // Receive FSM: first bit starts the PID, eighth bit enters the body, completion returns idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (bit_in_avail) state_d = StRxPid;
            StRxPid:  if (cnt_d >= CNT_W'(PidBits)) state_d = StRxBody;
            StRxBody: state_d = StRxBody;
            default:  state_d = StIdle;
        endcase
        if (complete) state_d = StIdle;
    end

    // Assembly state, cleared on completion ready for the next packet.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pid_q   <= '0;
            tok_q   <= '0;
            dly_q   <= '0;
            data_q  <= '0;
        end else if (complete) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pid_q   <= '0;
            tok_q   <= '0;
            dly_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pid_q   <= pid_d;
            tok_q   <= tok_d;
            dly_q   <= dly_d;
            data_q  <= data_d;
        end
    end

    // One-deep output buffer; a completion while the buffer is held is counted and dropped.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pkt_valid   <= 1'b0;
            pkt_pid     <= '0;
            pkt_kind    <= KindToken;
            pkt_addr    <= '0;
            pkt_endp    <= '0;
            pkt_data    <= '0;
            pkt_len     <= '0;
            pkt_pid_err <= 1'b0;
            pkt_crc_err <= 1'b0;
            pkt_len_err <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            if (load) begin
                pkt_valid   <= 1'b1;
                pkt_pid     <= pid_d[3:0];
                pkt_kind    <= dec_kind;
                pkt_addr    <= (dec_kind == KindToken) ? tok_d[6:0] : '0;
                pkt_endp    <= (dec_kind == KindToken) ? tok_d[10:7] : '0;
                pkt_data    <= (dec_kind == KindData) ? data_d : '0;
                pkt_len     <= dec_len;
                pkt_pid_err <= dec_pid_err;
                pkt_crc_err <= dec_crc_err;
                pkt_len_err <= dec_len_err;
            end else if (pkt_valid && pkt_ready) begin
                pkt_valid <= 1'b0;
            end
            if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: doc/usb_pkt_rx.md
# usb_pkt_rx

Parametrised bit-serial USB packet receiver with on-the-fly CRC checking, sitting between the NRZI/bit-unstuff front end and the protocol FSM. It assembles token, data and handshake packets of configurable maximum payload and validates PID/¬PID, CRC5, CRC16 and length. Each packet is delivered as a decoded record over a valid/ready handshake. A one-deep output buffer allows reception of the next packet to overlap delivery of the current one.

## Interface
- MAX_DATA_BYTES, 8, largest accepted data payload in bytes (1..64)
- CNT_W, derived, $clog2(8*MAX_DATA_BYTES+25), width of the bit counter
- clk  in  1  clock
- rst_b  in  1  reset; asynchronous, active-low
- bit_in_avail  in  1  bit_in valid this cycle; always consumed, no backpressure
- bit_in  in  1  received bit, wire order (LSB of each field first)
- eop  in  1  end-of-packet strobe; ends the packet after any bit consumed in the same cycle
- pkt_valid  out  1  decoded record available
- pkt_ready  in  1  consumer accepts the record
- pkt_pid  out  4  received PID
- pkt_kind  out  2  TOKEN / DATA / HANDSHAKE / BAD (from usb_pkg)
- pkt_addr  out  7  token address, 0 for other kinds
- pkt_endp  out  4  token endpoint, 0 for other kinds
- pkt_data  out  8*MAX_DATA_BYTES  payload; byte i at [8i+7:8i]; unused bytes 0
- pkt_len  out  $clog2(MAX_DATA_BYTES+1)  payload byte count, saturating at MAX_DATA_BYTES
- pkt_pid_err, pkt_crc_err, pkt_len_err  out  1 each  error flags
- drop_cnt  out  8  saturating count of packets lost to output overrun

## Operation
- Receive FSM states: IDLE, RX_PID, RX_BODY.
  - IDLE: the first consumed bit moves the FSM to RX_PID.
  - RX_PID: after 8 bits, moves to RX_BODY.
  - eop in any non-IDLE state: completes the packet and returns to IDLE.
  - eop in IDLE with no bits: ignored.
- PID byte = first 8 bits, with bit 0 first; PID = [3:0], check nibble = [7:4]. pid_err is set when the check nibble ≠ ~PID or the PID is reserved.
- Kind from PID[1:0]:
  - 01 TOKEN
  - 11 DATA (DATA0/DATA1 only, else BAD)
  - 10 HANDSHAKE
  - 00 BAD
  - any pid_err also gives BAD
- CRC runs over every bit after the PID byte, including the CRC field itself.
  - CRC5: init 5'h1F; next = {r[3:0],1'b0} ^ ((r[4]^b) ? 5'h05 : 0); good residue 5'h0C.
  - CRC16: init 16'hFFFF; next = {r[14:0],1'b0} ^ ((r[15]^b) ? 16'h8005 : 0); good residue 16'h800D.
  - Handshakes carry no CRC, so crc_err = 0.
- Lengths, counting the PID byte:
  - TOKEN: exactly 24 bits.
  - HANDSHAKE: exactly 8 bits.
  - DATA: 24+8N bits with 0 ≤ N ≤ MAX_DATA_BYTES.
  - Anything else, including fewer than 8 bits, sets len_err.
- Payload: the last 16 body bits of a DATA packet are CRC and are not stored.
  - Use a 16-bit delay line so only bits older than 16 are written to the payload.
- Overflow: body bits beyond the maximum are still fed to the CRC but not stored. Set len_err and saturate pkt_len.
- Completion copies the assembled record into the output buffer and sets pkt_valid. The assembly registers clear for the next packet.
- If pkt_valid && !pkt_ready at completion, the new packet is discarded. drop_cnt increments (saturating at 255) and the buffered record is unchanged.
- Completion in the same cycle as acceptance (pkt_valid && pkt_ready): the new record is loaded and pkt_valid stays 1.

## Timing
- Reset values: all outputs 0; FSM in IDLE; CRC registers at their init values.
- Each bit is sampled on the posedge where bit_in_avail = 1.
- eop on cycle T gives pkt_valid = 1 and a stable record from T+1.
- A new packet may start at T+1.
- pkt_valid holds until the posedge where pkt_ready = 1; it drops the following cycle unless a completion coincides.
- Record fields are stable while pkt_valid = 1.
- Reset mid-packet discards the partial packet and any buffered record.

## Structure
- Package usb_pkg holds:
  - PID constants and the kind enum
  - CRC5/CRC16 polynomial, init and residue constants
  - token/handshake length constants
- Sub-module usb_crc_lfsr (parameters WIDTH, POLY, INIT, RESIDUE; ports clk, rst_b, clr, en, bit, ok). It is instanced once for CRC5 and once for CRC16.

## Test plan
- SETUP token (PID 1101), addr 0x15, endp 0xE, CRC5 0x17 → pkt_kind TOKEN, addr 0x15, endp 0xE, all errors 0; pkt_valid high exactly one cycle after eop.
- DATA0 payload 00 01 02 03 with CRC16 0xF75E → kind DATA, pkt_len 4, pkt_data[31:0] = 0x03020100, no errors.
- Same packet with payload bit 9 flipped → pkt_crc_err 1, other flags 0.
- ACK with check nibble 0xE instead of ~0x2 → pkt_kind BAD, pkt_pid_err 1.
- Hold pkt_ready = 0; send OUT token then ACK → first record retained, drop_cnt = 1. Raise pkt_ready → pkt_valid drops next cycle.
- DATA1 with MAX_DATA_BYTES+1 bytes → pkt_len_err 1, pkt_len = MAX_DATA_BYTES. Then assert rst_b low mid-token → all outputs 0; the next clean packet decodes correctly.
